reg_write_trace_buffer: RTL and testbench



---
 rtl/reg_write_trace_buffer.sv | 138 +++++++++++++
 tb/tb_reg_write_trace_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_trace_buffer.sv
// Trace buffer beside the register-file write port: records {ts, pc, reg, data} circularly,
// halts on a PC trigger (plus post-trigger writes) or a cycle timeout, then reads out oldest-first.
module reg_write_trace_buffer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned PC_WIDTH       = 12,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TS_WIDTH       = 16,
    parameter int unsigned POST_TRIG      = 4,
    parameter int unsigned MAX_CYCLES     = 100,
    parameter bit          WRAP           = 1'b1
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   capture_en,
    input  logic                                                   ctrl_writeEnable,
    input  logic [REG_ADDR_WIDTH-1:0]                              ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]                                  data_writeReg,
    input  logic [PC_WIDTH-1:0]                                    pc,
    input  logic                                                   trigger_arm,
    input  logic [PC_WIDTH-1:0]                                    trigger_pc,
    input  logic                                                   rd_en,
    output logic [TS_WIDTH+PC_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH-1:0] rd_data,
    output logic                                                   rd_valid,
    output logic [$clog2(DEPTH):0]                                 count,
    output logic                                                   overflow,
    output logic                                                   triggered,
    output logic                                                   halt
);

    localparam int unsigned EW = TS_WIDTH + PC_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(POST_TRIG + 1) + 1;

    typedef enum logic [1:0] {StRun, StPost, StHalted} state_e;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] cyc_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       post_q, post_d;
    logic [EW-1:0]       rd_data_q;
    logic                rd_valid_q, overflow_q, triggered_q;
    logic [EW-1:0]       mem [DEPTH];

    logic capture, full, trig_hit, timeout, pop, write_mem;

    always_comb begin
        capture   = capture_en & ctrl_writeEnable & (ctrl_writeReg != '0) & (state_q != StHalted);
        full      = (count_q == CW'(DEPTH));
        trig_hit  = (state_q == StRun) & trigger_arm & (pc == trigger_pc);
        timeout   = (MAX_CYCLES != 0) && (state_q != StHalted) &&
                    (cyc_q == TS_WIDTH'(MAX_CYCLES - 1));
        pop       = (state_q == StHalted) & rd_en & (count_q != '0);
        write_mem = capture & (~full | WRAP);
    end

    // Timeout takes priority over a same-cycle trigger; dropped writes still count down in POST.
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        unique case (state_q)
            StRun: begin
                if (timeout) begin
                    state_d = StHalted;
                end else if (trig_hit) begin
                    if (POST_TRIG == 0) begin
                        state_d = StHalted;
                    end else begin
                        state_d = StPost;
                        post_d  = PW'(POST_TRIG);
                    end
                end
            end
            StPost: begin
                if (timeout) begin
                    state_d = StHalted;
                end else if (capture) begin
                    post_d = post_q - PW'(1);
                    if (post_q == PW'(1)) state_d = StHalted;
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock) begin
        if (write_mem) mem[wr_ptr_q] <= {cyc_q, pc, ctrl_writeReg, data_writeReg};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            cyc_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            post_q      <= post_d;
            rd_valid_q  <= pop;
            triggered_q <= triggered_q | trig_hit;
            if (state_q != StHalted && cyc_q != '1) cyc_q <= cyc_q + TS_WIDTH'(1);
            if (capture) begin
                if (!full) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    count_q  <= count_q + CW'(1);
                end else begin
                    overflow_q <= 1'b1;
                    if (WRAP) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                end
            end
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                count_q   <= count_q - CW'(1);
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign halt      = (state_q == StHalted);

endmodule

// File: tb/tb_reg_write_trace_buffer.sv
// Bench for reg_write_trace_buffer: five configurations share one stimulus stream, checked
// every cycle against a queue-based model plus directed vectors and corner sequences.
module tb_reg_write_trace_buffer;

    localparam int NI = 5;
    localparam int EW = 16 + 12 + 5 + 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        capture_en, we, trigger_arm, rd_en;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [11:0] pc, trigger_pc;

    logic [EW-1:0] rdd [NI];
    logic          rdv [NI];
    logic          ovf [NI];
    logic          trg [NI];
    logic          hlt [NI];
    logic [4:0]    cnt [NI];
    logic [4:0]    c0, c3, c4;
    logic [2:0]    c1, c2;

    assign cnt[0] = c0;
    assign cnt[1] = {2'b00, c1};
    assign cnt[2] = {2'b00, c2};
    assign cnt[3] = c3;
    assign cnt[4] = c4;

    always #5 clock = ~clock;

    reg_write_trace_buffer #(.DEPTH(16), .POST_TRIG(0), .MAX_CYCLES(0), .WRAP(1'b1)) u0 (
        .clock(clock), .reset(reset), .capture_en(capture_en), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .pc(pc), .trigger_arm(trigger_arm),
        .trigger_pc(trigger_pc), .rd_en(rd_en), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .count(c0), .overflow(ovf[0]), .triggered(trg[0]), .halt(hlt[0]));
    reg_write_trace_buffer #(.DEPTH(4), .POST_TRIG(0), .MAX_CYCLES(0), .WRAP(1'b1)) u1 (
        .clock(clock), .reset(reset), .capture_en(capture_en), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .pc(pc), .trigger_arm(trigger_arm),
        .trigger_pc(trigger_pc), .rd_en(rd_en), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .count(c1), .overflow(ovf[1]), .triggered(trg[1]), .halt(hlt[1]));
    reg_write_trace_buffer #(.DEPTH(4), .POST_TRIG(0), .MAX_CYCLES(0), .WRAP(1'b0)) u2 (
        .clock(clock), .reset(reset), .capture_en(capture_en), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .pc(pc), .trigger_arm(trigger_arm),
        .trigger_pc(trigger_pc), .rd_en(rd_en), .rd_data(rdd[2]), .rd_valid(rdv[2]),
        .count(c2), .overflow(ovf[2]), .triggered(trg[2]), .halt(hlt[2]));
    reg_write_trace_buffer #(.DEPTH(16), .POST_TRIG(2), .MAX_CYCLES(0), .WRAP(1'b1)) u3 (
        .clock(clock), .reset(reset), .capture_en(capture_en), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .pc(pc), .trigger_arm(trigger_arm),
        .trigger_pc(trigger_pc), .rd_en(rd_en), .rd_data(rdd[3]), .rd_valid(rdv[3]),
        .count(c3), .overflow(ovf[3]), .triggered(trg[3]), .halt(hlt[3]));
    reg_write_trace_buffer #(.DEPTH(16), .POST_TRIG(0), .MAX_CYCLES(100), .WRAP(1'b1)) u4 (
        .clock(clock), .reset(reset), .capture_en(capture_en), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .pc(pc), .trigger_arm(trigger_arm),
        .trigger_pc(trigger_pc), .rd_en(rd_en), .rd_data(rdd[4]), .rd_valid(rdv[4]),
        .count(c4), .overflow(ovf[4]), .triggered(trg[4]), .halt(hlt[4]));

    // Reference model: per-instance configuration and a plain queue of recorded entries.
    int            m_depth [NI] = '{16, 4, 4, 16, 16};
    bit            m_wrap  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int            m_ptrig [NI] = '{0, 0, 0, 2, 0};
    int            m_maxc  [NI] = '{0, 0, 0, 0, 100};
    logic [EW-1:0] m_q     [NI][$];
    bit            m_halt [NI], m_inpost [NI], m_ovf [NI], m_trg [NI], m_rdv [NI];
    int            m_left [NI], m_cyc [NI];
    logic [EW-1:0] m_rdd  [NI];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_q[k].delete();
            m_halt[k] = 0; m_inpost[k] = 0; m_ovf[k] = 0; m_trg[k] = 0; m_rdv[k] = 0;
            m_left[k] = 0; m_cyc[k] = 0; m_rdd[k] = '0;
        end
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        for (int k = 0; k < NI; k++) begin
            bit cap, trig, tmo;
            logic [EW-1:0] e;
            m_rdv[k] = 0;
            if (m_halt[k]) begin
                if (rd_en && m_q[k].size() > 0) begin
                    m_rdd[k] = m_q[k].pop_front();
                    m_rdv[k] = 1;
                end
                continue;
            end
            cap  = capture_en && we && (wreg != 0);
            trig = !m_inpost[k] && trigger_arm && (pc == trigger_pc);
            tmo  = (m_maxc[k] != 0) && (m_cyc[k] == m_maxc[k] - 1);
            e    = {16'(m_cyc[k]), pc, wreg, wdata};
            if (cap) begin
                if (m_q[k].size() < m_depth[k]) begin
                    m_q[k].push_back(e);
                end else begin
                    m_ovf[k] = 1;
                    if (m_wrap[k]) begin
                        void'(m_q[k].pop_front());
                        m_q[k].push_back(e);
                    end
                end
            end
            if (trig) m_trg[k] = 1;
            if (tmo) m_halt[k] = 1;
            else if (trig) begin
                if (m_ptrig[k] == 0) m_halt[k] = 1;
                else begin
                    m_inpost[k] = 1;
                    m_left[k] = m_ptrig[k];
                end
            end else if (m_inpost[k] && cap) begin
                m_left[k]--;
                if (m_left[k] == 0) m_halt[k] = 1;
            end
            if (m_cyc[k] < 65535) m_cyc[k]++;
        end
    endfunction

    task automatic model_check();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model halt[%0d]", k), 128'(hlt[k]), 128'(m_halt[k]));
            chk($sformatf("model count[%0d]", k), 128'(cnt[k]), 128'(m_q[k].size()));
            chk($sformatf("model overflow[%0d]", k), 128'(ovf[k]), 128'(m_ovf[k]));
            chk($sformatf("model triggered[%0d]", k), 128'(trg[k]), 128'(m_trg[k]));
            chk($sformatf("model rd_valid[%0d]", k), 128'(rdv[k]), 128'(m_rdv[k]));
            chk($sformatf("model rd_data[%0d]", k), 128'(rdd[k]), 128'(m_rdd[k]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        model_check();
    endtask

    task automatic set_wr(input logic w, input int r, input logic [31:0] d, input int p);
        we = w;
        wreg = 5'(r);
        wdata = d;
        pc = 12'(p);
    endtask

    task automatic do_reset();
        capture_en = 1'b1; rd_en = 1'b0; trigger_arm = 1'b0; trigger_pc = 12'h010;
        set_wr(1'b0, 0, 32'h0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        model_check();
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
        logic [11:0] pc;
        logic [4:0]  exp_cnt;
        logic        exp_halt;
    } vec_t;

    vec_t          tv [7];
    logic [EW-1:0] exp_e;

    initial begin
        tv[0] = '{1'b0, 5'd0, 32'h00, 12'd0,  5'd0, 1'b0};
        tv[1] = '{1'b0, 5'd0, 32'h00, 12'd0,  5'd0, 1'b0};
        tv[2] = '{1'b1, 5'd1, 32'h11, 12'd4,  5'd1, 1'b0};
        tv[3] = '{1'b1, 5'd2, 32'h22, 12'd8,  5'd2, 1'b0};
        tv[4] = '{1'b0, 5'd0, 32'h00, 12'd0,  5'd2, 1'b0};
        tv[5] = '{1'b1, 5'd3, 32'h33, 12'd12, 5'd3, 0};
        tv[6] = '{1'b0, 5'd0, 32'h00, 12'd16, 5'd3, 1'b1};

        // Basic capture, trigger halt with no post-trigger writes, oldest-first readout.
        do_reset();
        chk("reset halt", 128'(hlt[0]), 128'(0));
        chk("reset count", 128'(cnt[0]), 128'(0));
        chk("reset rd_data", 128'(rdd[0]), 128'(0));
        trigger_arm = 1'b1;
        for (int i = 0; i < 7; i++) begin
            we = tv[i].we; wreg = tv[i].r; wdata = tv[i].d; pc = tv[i].pc;
            tick();
            chk($sformatf("vec%0d count", i), 128'(cnt[0]), 128'(tv[i].exp_cnt));
            chk($sformatf("vec%0d halt", i), 128'(hlt[0]), 128'(tv[i].exp_halt));
        end
        set_wr(1'b0, 0, 32'h0, 0);
        rd_en = 1'b1;
        tick();
        exp_e = {16'd2, 12'd4, 5'd1, 32'h11};
        chk("pop1", 128'(rdd[0]), 128'(exp_e));
        tick();
        exp_e = {16'd3, 12'd8, 5'd2, 32'h22};
        chk("pop2", 128'(rdd[0]), 128'(exp_e));
        tick();
        exp_e = {16'd5, 12'd12, 5'd3, 32'h33};
        chk("pop3", 128'(rdd[0]), 128'(exp_e));
        chk("pop3 valid", 128'(rdv[0]), 128'(1));
        tick();
        chk("pop empty valid", 128'(rdv[0]), 128'(0));
        chk("pop empty hold", 128'(rdd[0]), 128'(exp_e));
        chk("basic overflow", 128'(ovf[0]), 128'(0));
        rd_en = 1'b0;

        // r0 writes and writes with capture disabled are never recorded.
        do_reset();
        set_wr(1'b1, 0, 32'h99, 0);
        tick();
        capture_en = 1'b0;
        set_wr(1'b1, 5, 32'h55, 0);
        tick();
        chk("r0/disabled count", 128'(cnt[0]), 128'(0));
        capture_en = 1'b1;

        // Full buffer: WRAP=1 keeps the newest four, WRAP=0 keeps the oldest four.
        do_reset();
        trigger_arm = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            set_wr(1'b1, i, 32'(i), 0);
            tick();
        end
        set_wr(1'b0, 0, 32'h0, 16);
        tick();
        chk("wrap halt", 128'(hlt[1]), 128'(1));
        chk("wrap count", 128'(cnt[1]), 128'(4));
        chk("wrap overflow", 128'(ovf[1]), 128'(1));
        chk("drop count", 128'(cnt[2]), 128'(4));
        chk("drop overflow", 128'(ovf[2]), 128'(1));
        pc = 12'd0;
        rd_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("wrap pop%0d", j), 128'(rdd[1][31:0]), 128'(3 + j));
            chk($sformatf("drop pop%0d", j), 128'(rdd[2][31:0]), 128'(1 + j));
        end
        rd_en = 1'b0;

        // Post-trigger countdown: halt on the edge of the second write after the trigger.
        do_reset();
        trigger_arm = 1'b1;
        trigger_pc = 12'h020;
        for (int i = 0; i < 5; i++) begin
            set_wr(1'b1, 1, 32'(12'h01C + 4 * i), 12'h01C + 4 * i);
            tick();
            if (i == 0) chk("post trig early", 128'(trg[3]), 128'(0));
            if (i == 1) chk("post triggered", 128'(trg[3]), 128'(1));
            if (i == 2) chk("post halt early", 128'(hlt[3]), 128'(0));
            if (i == 3) chk("post halt", 128'(hlt[3]), 128'(1));
            if (i == 4) chk("post count", 128'(cnt[3]), 128'(4));
        end
        set_wr(1'b0, 0, 32'h0, 0);

        // Timeout at cycle 99 with one write per cycle.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            set_wr(1'b1, (i % 31) + 1, 32'(i), i);
            tick();
            if (i == 98) chk("timeout early", 128'(hlt[4]), 128'(0));
            if (i == 99) chk("timeout halt", 128'(hlt[4]), 128'(1));
        end
        set_wr(1'b0, 0, 32'h0, 0);
        chk("timeout count", 128'(cnt[4]), 128'(16));
        chk("timeout overflow", 128'(ovf[4]), 128'(1));
        rd_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            chk($sformatf("timeout pop%0d", j), 128'(rdd[4][31:0]), 128'(84 + j));
            if (j == 15) chk("timeout last ts", 128'(rdd[4][EW-1 -: 16]), 128'(99));
        end
        tick();
        chk("timeout extra pop", 128'(rdv[4]), 128'(0));
        rd_en = 1'b0;

        // Asynchronous reset in the middle of readout.
        do_reset();
        trigger_arm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, i + 1, 32'(8'hA0 + i), 0);
            tick();
        end
        set_wr(1'b0, 0, 32'h0, 16);
        tick();
        pc = 12'd0;
        rd_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("async halt", 128'(hlt[0]), 128'(0));
        chk("async count", 128'(cnt[0]), 128'(0));
        chk("async rd_valid", 128'(rdv[0]), 128'(0));
        model_reset();
        rd_en = 1'b0;
        #2;
        reset = 1'b0;
        set_wr(1'b1, 7, 32'h77, 0);
        tick();
        set_wr(1'b0, 0, 32'h0, 16);
        tick();
        pc = 12'd0;
        rd_en = 1'b1;
        tick();
        exp_e = {16'd0, 12'd0, 5'd7, 32'h77};
        chk("post-reset ts0", 128'(rdd[0]), 128'(exp_e));
        rd_en = 1'b0;

        // Randomized episodes checked against the model every cycle.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            trigger_pc = 12'($urandom_range(0, 7));
            for (int c = 0; c < 120; c++) begin
                capture_en  = ($urandom_range(0, 7) != 0);
                trigger_arm = ($urandom_range(0, 2) == 0);
                rd_en       = 1'($urandom_range(0, 1));
                set_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                       int'($urandom_range(0, 7)));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
